// File: rtl/gpio_input_conditioner_if.sv
// Bundles the per-pin GPIO conditioner signals between the board pads and the SoC input path.
// The master side drives pad levels and software controls; the slave side is the conditioner.
interface gpio_input_conditioner_if #(
    parameter int GPIO_WIDTH = 3
);
    logic [GPIO_WIDTH-1:0] gpio_pin_in;
    logic [GPIO_WIDTH-1:0] rise_enable;
    logic [GPIO_WIDTH-1:0] fall_enable;
    logic [GPIO_WIDTH-1:0] clear_pending;
    logic [GPIO_WIDTH-1:0] gpio_stable;
    logic [GPIO_WIDTH-1:0] rise_pulse;
    logic [GPIO_WIDTH-1:0] fall_pulse;
    logic [GPIO_WIDTH-1:0] pending;
    logic                  irq;

    modport master (
        output gpio_pin_in, rise_enable, fall_enable, clear_pending,
        input  gpio_stable, rise_pulse, fall_pulse, pending, irq
    );

    modport slave (
        input  gpio_pin_in, rise_enable, fall_enable, clear_pending,
        output gpio_stable, rise_pulse, fall_pulse, pending, irq
    );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-pin synchroniser, debouncer and edge detector, with sticky edge events and a level interrupt.
// A pin's debounced level only changes after its synchronised value has disagreed for DEBOUNCE_CYCLES edges.
module gpio_input_conditioner #(
    parameter int GPIO_WIDTH      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input logic                      clock,
    input logic                      reset_n,
    gpio_input_conditioner_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0] stable_vec;
    logic [GPIO_WIDTH-1:0] rise_vec;
    logic [GPIO_WIDTH-1:0] fall_vec;
    logic [GPIO_WIDTH-1:0] pending_reg;
    logic [GPIO_WIDTH-1:0] pending_next;

    genvar gi;
    generate
        for (gi = 0; gi < GPIO_WIDTH; gi++) begin : g_pin
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   stable_reg;
            logic                   rise_reg;
            logic                   fall_reg;
            logic                   sync_bit;

            assign sync_bit = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.gpio_pin_in[gi]};
                end
            end

            // The counter only runs while the synchronised pin disagrees with the
            // accepted level; any agreement, however brief, restarts it.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                end else begin
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    if (sync_bit != stable_reg) begin
                        if (cnt_reg == CNT_LAST) begin
                            cnt_reg    <= '0;
                            stable_reg <= sync_bit;
                            rise_reg   <= sync_bit;
                            fall_reg   <= ~sync_bit;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign stable_vec[gi] = stable_reg;
            assign rise_vec[gi]   = rise_reg;
            assign fall_vec[gi]   = fall_reg;
        end
    endgenerate

    // A new event in the same cycle as its clear survives, so no edge is lost.
    always_comb begin
        pending_next = (pending_reg & ~bus.clear_pending)
                     | (rise_vec & bus.rise_enable)
                     | (fall_vec & bus.fall_enable);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign bus.gpio_stable = stable_vec;
    assign bus.rise_pulse  = rise_vec;
    assign bus.fall_pulse  = fall_vec;
    assign bus.pending     = pending_reg;
    assign bus.irq         = |pending_reg;
endmodule
